// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the front end: opcodes, the reset NOP,
// fetch FSM state type and immediate-extraction helpers.
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] get_imm_i(input logic [31:0] insn);
        return {{20{insn[31]}}, insn[31:20]};
    endfunction

    function automatic logic [31:0] get_imm_s(input logic [31:0] insn);
        return {{20{insn[31]}}, insn[31:25], insn[11:7]};
    endfunction

    function automatic logic [31:0] get_imm_b(input logic [31:0] insn);
        return {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] get_imm_u(input logic [31:0] insn);
        return {insn[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] get_imm_j(input logic [31:0] insn);
        return {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Sign-extended RV32I immediates (I/S/B/U/J) from a raw instruction word.
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);

    assign imm_i = get_imm_i(instruction);
    assign imm_s = get_imm_s(instruction);
    assign imm_b = get_imm_b(instruction);
    assign imm_u = get_imm_u(instruction);
    assign imm_j = get_imm_j(instruction);

endmodule

// File: rtl/if_id_stage.sv
// RV32I fetch stage plus IF/ID register. Streams sequential fetches from a
// 1-cycle registered IMEM, redirects on JAL, and halts (sticky exception)
// on an illegal opcode or a misaligned fetch PC.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 17
) (
    input  logic        clk,
    input  logic        reset,
    output logic        exception,
    output logic        inst_mem_is_ready,
    input  logic [31:0] inst_mem_read_data,
    output logic        inst_mem_is_valid,
    output logic [31:0] inst_mem_addr
);
    import rv32_pkg::*;

    fetch_state_t state, state_next;

    logic [31:0] inst_fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] instruction;
    logic [31:0] id_pc;
    logic        id_valid;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic redirect, illegal, misaligned, halt_req, run;

    // Field decode of the IF/ID instruction.
    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    rv32_imm_gen u_imm_gen (
        .instruction (instruction),
        .imm_i       (imm_i),
        .imm_s       (imm_s),
        .imm_b       (imm_b),
        .imm_u       (imm_u),
        .imm_j       (imm_j)
    );

    // id_valid separates a freshly captured word from the reset NOP or a
    // stale word left behind by a squash, so a JAL redirects exactly once.
    assign redirect   = id_valid & (opcode == OP_JAL);
    assign illegal    = id_valid & ~is_legal_opcode(opcode);
    assign misaligned = (inst_fetch_pc[1:0] != 2'b00);
    assign halt_req   = illegal | misaligned;

    // Fetch state advances only while not halted and not about to halt,
    // so the PC freezes at the faulting value.
    assign run = (state != ST_HALT) & ~halt_req;

    assign exception         = (state == ST_HALT);
    assign inst_mem_is_ready = reset & (state != ST_HALT);
    assign inst_mem_addr     = inst_fetch_pc;

    // Fetch FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_RESET;
        else        state <= state_next;
    end

    // Fetch FSM next state: leave RESET on the first edge, HALT is terminal.
    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = halt_req ? ST_HALT : ST_FETCH;
            ST_FETCH: if (halt_req) state_next = ST_HALT;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_HALT;
        endcase
    end

    // PC, request tracking and IF/ID capture. While a JAL redirects, the
    // word returning this edge (fetched behind the JAL) is dropped and the
    // request in flight is marked not-valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_fetch_pc     <= RESET_PC;
            req_pc            <= RESET_PC;
            inst_mem_is_valid <= 1'b0;
            instruction       <= NOP_INSN;
            id_pc             <= 32'h0;
            id_valid          <= 1'b0;
        end else if (run) begin
            inst_fetch_pc     <= redirect ? (id_pc + imm_j) : (inst_fetch_pc + 32'd4);
            req_pc            <= inst_fetch_pc;
            inst_mem_is_valid <= ~redirect;
            id_valid          <= inst_mem_is_valid & ~redirect;
            if (inst_mem_is_valid && !redirect) begin
                instruction <= inst_mem_read_data;
                id_pc       <= req_pc;
            end
        end else begin
            inst_mem_is_valid <= 1'b0;
        end
    end

    // Decode outputs consumed by the next stage, not by this one.
    logic decode_unused;
    assign decode_unused = ^{rd, funct3, rs1, rs2, funct7, imm_i, imm_s, imm_b, imm_u,
                             inst_fetch_pc[31:IMEM_AW]};

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with a 1-cycle registered IMEM model.
module tb_if_id_stage;

    logic        clk;
    logic        reset;
    logic        exception;
    logic        inst_mem_is_ready;
    logic [31:0] inst_mem_read_data;
    logic        inst_mem_is_valid;
    logic [31:0] inst_mem_addr;

    logic [31:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    if_id_stage dut (
        .clk                (clk),
        .reset              (reset),
        .exception          (exception),
        .inst_mem_is_ready  (inst_mem_is_ready),
        .inst_mem_read_data (inst_mem_read_data),
        .inst_mem_is_valid  (inst_mem_is_valid),
        .inst_mem_addr      (inst_mem_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // registered IMEM read
    always @(posedge clk) inst_mem_read_data <= mem[inst_mem_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 256; i++) mem[i] = w;
    endtask

    task automatic restart();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    logic [31:0] prev_pc;
    logic [31:0] addr_hi;

    initial begin
        reset = 1'b0;
        fill(32'h0000_0013);

        // 1: reset hold, then sequential PC
        repeat (10) @(negedge clk);
        chk("t1_rst_pc",    dut.inst_fetch_pc, 32'h0);
        chk("t1_rst_exc",   32'(exception), 32'h0);
        chk("t1_rst_rdy",   32'(inst_mem_is_ready), 32'h0);
        chk("t1_rst_vld",   32'(inst_mem_is_valid), 32'h0);
        chk("t1_rst_insn",  dut.instruction, 32'h13);
        reset = 1'b1;
        #1;
        chk("t1_pc0",  dut.inst_fetch_pc, 32'h0);
        chk("t1_rdy",  32'(inst_mem_is_ready), 32'h1);
        step(); chk("t1_pc4",  dut.inst_fetch_pc, 32'h4);
        step(); chk("t1_pc8",  dut.inst_fetch_pc, 32'h8);
        step(); chk("t1_pcC",  inst_mem_addr, 32'hC);

        // 2: short program ending in an all-zero word
        fill(32'h0);
        mem[0] = 32'h0000_0013; mem[1] = 32'h0010_0093; mem[2] = 32'h0020_0113; mem[3] = 32'h0;
        restart();
        step();
        step(); chk("t2_i0", dut.instruction, 32'h0000_0013);
        step(); chk("t2_i1", dut.instruction, 32'h0010_0093);
        step(); chk("t2_i2", dut.instruction, 32'h0020_0113);
        step(); chk("t2_i3", dut.instruction, 32'h0);
        chk("t2_exc_pre", 32'(exception), 32'h0);
        step(); chk("t2_exc", 32'(exception), 32'h1);
        chk("t2_rdy",  32'(inst_mem_is_ready), 32'h0);
        chk("t2_pc",   dut.inst_fetch_pc, 32'h14);
        step(); chk("t2_pc_hold", dut.inst_fetch_pc, 32'h14);
        chk("t2_vld",  32'(inst_mem_is_valid), 32'h0);
        chk("t2_insn_hold", dut.instruction, 32'h0);

        // 3: JAL x0,+8 at 0 squashes the word at 4
        fill(32'h0000_0013);
        mem[0] = 32'h0080_006F; mem[1] = 32'h0010_0093; mem[2] = 32'h0030_0193;
        restart();
        step(); chk("t3_pc4",  dut.inst_fetch_pc, 32'h4);
        step(); chk("t3_jal",  dut.instruction, 32'h0080_006F);
        chk("t3_pc8a", dut.inst_fetch_pc, 32'h8);
        step(); chk("t3_squash", 32'(inst_mem_is_valid), 32'h0);
        chk("t3_pc8b", dut.inst_fetch_pc, 32'h8);
        chk("t3_insn_keep", dut.instruction, 32'h0080_006F);
        step(); chk("t3_pcC", dut.inst_fetch_pc, 32'hC);
        chk("t3_vld", 32'(inst_mem_is_valid), 32'h1);
        step(); chk("t3_target", dut.instruction, 32'h0030_0193);
        chk("t3_pc10", dut.inst_fetch_pc, 32'h10);
        step(); chk("t3_next", dut.instruction, 32'h0000_0013);
        chk("t3_exc", 32'(exception), 32'h0);

        // 4: JAL to +2 (misaligned target)
        fill(32'h0000_0013);
        mem[0] = 32'h0020_006F;
        restart();
        step();
        step(); chk("t4_jal", dut.instruction, 32'h0020_006F);
        step(); chk("t4_pc2", dut.inst_fetch_pc, 32'h2);
        chk("t4_exc_pre", 32'(exception), 32'h0);
        step(); chk("t4_exc", 32'(exception), 32'h1);
        chk("t4_rdy", 32'(inst_mem_is_ready), 32'h0);
        chk("t4_pc_hold", dut.inst_fetch_pc, 32'h2);
        step(); chk("t4_pc_hold2", dut.inst_fetch_pc, 32'h2);

        // 5: asynchronous reset mid-run at PC 0x40
        fill(32'h0000_0013);
        restart();
        for (int i = 0; i < 100 && dut.inst_fetch_pc != 32'h40; i++) step();
        chk("t5_reach", dut.inst_fetch_pc, 32'h40);
        #2 reset = 1'b0;
        #1;
        chk("t5_pc",   dut.inst_fetch_pc, 32'h0);
        chk("t5_exc",  32'(exception), 32'h0);
        chk("t5_rdy",  32'(inst_mem_is_ready), 32'h0);
        chk("t5_vld",  32'(inst_mem_is_valid), 32'h0);
        chk("t5_insn", dut.instruction, 32'h13);
        step(); chk("t5_pc_held", dut.inst_fetch_pc, 32'h0);
        @(negedge clk); reset = 1'b1;
        step(); chk("t5_restart", dut.inst_fetch_pc, 32'h4);

        // 6: long NOP run
        restart();
        addr_hi = 32'h0;
        for (int i = 0; i < 120; i++) begin
            prev_pc = dut.inst_fetch_pc;
            step();
            chk("t6_step", dut.inst_fetch_pc, prev_pc + 32'd4);
            addr_hi = addr_hi | {17'h0, inst_mem_addr[31:17]};
        end
        chk("t6_exc",    32'(exception), 32'h0);
        chk("t6_window", addr_hi, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
